// File: rtl/duc_core_if.sv
// duc_core_if: AXI-Stream data/valid/ready bundle with parameterised data width
interface duc_core_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master(output tdata, output tvalid, input tready);
  modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/duc_core.sv
// duc_core: complex mix of baseband I/Q with DDS cos/sin into a rounded, saturated 2x16-bit DAC word
module duc_core #(
  parameter int SHIFT = 31,
  parameter int SAT_CNT_W = 16
) (
  input logic s_axis_aclk,
  input logic s_axis_areset,
  duc_core_if.slave s_axis_iq,
  duc_core_if.slave s_axis_dds,
  duc_core_if.master m_axis,
  input logic resync,
  output logic [SAT_CNT_W-1:0] sat_count
);
  localparam logic signed [49:0] RND = 50'sd1 <<< (SHIFT - 1);
  logic ce, go;
  logic v1, v2, v3, sat4;
  logic signed [31:0] i1, q1;
  logic signed [15:0] c1, s1;
  logic signed [47:0] p_ic, p_qs, p_is, p_qc;
  logic signed [48:0] re3, im3;
  logic signed [49:0] re_x, im_x;
  logic re_sat, im_sat;
  logic [15:0] re_w, im_w;
  assign ce = m_axis.tready | ~m_axis.tvalid;
  assign s_axis_iq.tready = ce & s_axis_dds.tvalid & ~resync & ~s_axis_areset;
  assign s_axis_dds.tready = ce & s_axis_iq.tvalid & ~resync & ~s_axis_areset;
  assign go = ce & s_axis_iq.tvalid & s_axis_dds.tvalid;
  // round half up, then clamp each lane to the signed 16-bit range
  always_comb begin
    re_x = (50'(re3) + RND) >>> SHIFT;
    im_x = (50'(im3) + RND) >>> SHIFT;
    re_sat = re_x > 50'sd32767 || re_x < -50'sd32768;
    im_sat = im_x > 50'sd32767 || im_x < -50'sd32768;
    re_w = re_x > 50'sd32767 ? 16'h7fff : re_x < -50'sd32768 ? 16'h8000 : re_x[15:0];
    im_w = im_x > 50'sd32767 ? 16'h7fff : im_x < -50'sd32768 ? 16'h8000 : im_x[15:0];
  end
  // four-stage pipeline frozen as a whole when the output is stalled; resync drops every beat in flight
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      {v1, v2, v3, sat4} <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata <= '0;
      sat_count <= '0;
      {i1, q1, c1, s1} <= '0;
      {p_ic, p_qs, p_is, p_qc} <= '0;
      {re3, im3} <= '0;
    end else if (resync) begin
      {v1, v2, v3} <= '0;
      m_axis.tvalid <= 1'b0;
      sat_count <= '0;
    end else begin
      if (m_axis.tvalid & m_axis.tready & sat4 & ~&sat_count) sat_count <= sat_count + SAT_CNT_W'(1);
      if (ce) begin
        v1 <= go;
        i1 <= s_axis_iq.tdata[31:0];
        q1 <= s_axis_iq.tdata[63:32];
        c1 <= s_axis_dds.tdata[15:0];
        s1 <= s_axis_dds.tdata[31:16];
        v2 <= v1;
        p_ic <= 48'(i1) * 48'(c1);
        p_qs <= 48'(q1) * 48'(s1);
        p_is <= 48'(i1) * 48'(s1);
        p_qc <= 48'(q1) * 48'(c1);
        v3 <= v2;
        re3 <= 49'(p_ic) - 49'(p_qs);
        im3 <= 49'(p_is) + 49'(p_qc);
        m_axis.tvalid <= v3;
        m_axis.tdata <= {im_w, re_w};
        sat4 <= re_sat | im_sat;
      end
    end
  end
endmodule
